// File: rtl/cop_pkg.sv
// Shared opcode values and FSM encoding for the coprocessor responder.
package cop_pkg;

  localparam logic [3:0] OP_ADD64 = 4'd0;
  localparam logic [3:0] OP_SUB64 = 4'd1;
  localparam logic [3:0] OP_MUL32 = 4'd2;
  localparam logic [3:0] OP_DIV32 = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL32) || (op == OP_DIV32);
  endfunction

endpackage

// File: rtl/cop_muldiv_unit.sv
// Iterative unsigned multiplier (shift-add) / restoring divider, ITER_BITS bits per cycle.
// For div, result = {remainder, quotient}; for mul, result = full product.
module cop_muldiv_unit
  import cop_pkg::*;
#(
  parameter int DW        = 32,
  parameter int ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] result
);

  localparam int STEPS = DW / ITER_BITS;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(STEPS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          run_q, div_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] a_q, b_q, hi_q, lo_q;
  logic [DW-1:0] hi_d, lo_d;

  // hi/lo hold {upper partial product, shifting multiplier} for mul and
  // {partial remainder, shifting dividend/quotient} for div.
  always_comb begin
    logic [DW:0] r;
    logic [DW:0] s;
    r    = '0;
    s    = '0;
    hi_d = hi_q;
    lo_d = lo_q;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (div_q) begin
        r    = {hi_d, lo_d[DW-1]};
        lo_d = {lo_d[DW-2:0], 1'b0};
        if (r >= {1'b0, b_q}) begin
          r       = r - {1'b0, b_q};
          lo_d[0] = 1'b1;
        end
        hi_d = r[DW-1:0];
      end else begin
        s    = {1'b0, hi_d} + (lo_d[0] ? {1'b0, a_q} : '0);
        lo_d = {s[0], lo_d[DW-1:1]};
        hi_d = s[DW:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      div_q <= is_div;
      cnt_q <= CNT_INIT;
      a_q   <= a;
      b_q   <= b;
      hi_q  <= '0;
      lo_q  <= is_div ? a : b;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
        hi_q  <= hi_d;
        lo_q  <= lo_d;
      end
    end
  end

  assign done   = run_q && (cnt_q == '0);
  assign result = {hi_q, lo_q};

endmodule

// File: rtl/cop_responder.sv
// Coprocessor responder: accepts one command per COP_GO, returns a 2*DW result with a DONE pulse.
// Add/sub finish in one EXEC cycle; mul/div wait on the iterative unit.
module cop_responder
  import cop_pkg::*;
#(
  parameter int DW        = 32,
  parameter int ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            COP_GO,
  input  logic [23:0]     COP_OP,
  input  logic [4*DW-1:0] COP_OUT,
  output logic            COP_DONE,
  output logic [2*DW-1:0] COP_IN,
  output logic            busy,
  output logic            err
);

  state_t          state_q, state_d;
  logic [3:0]      op_q;
  logic [2*DW-1:0] a64_q, b64_q;
  logic            dz_q;
  logic [2*DW-1:0] cop_in_q, res_d;
  logic            err_q, err_d, fin_load;
  logic            accept, md_start, md_done, dz_in;
  logic [2*DW-1:0] md_result;
  logic            unused_op_hi;

  assign unused_op_hi = ^COP_OP[23:4];
  assign accept   = (state_q == S_IDLE) && COP_GO;
  assign dz_in    = (COP_OUT[2*DW-1:DW] == '0);
  // The unit loads straight from the input bus on the accept edge so that its
  // iterations overlap the first EXEC cycle; div-by-zero never starts it.
  assign md_start = accept && is_muldiv(COP_OP[3:0]) &&
                    !((COP_OP[3:0] == OP_DIV32) && dz_in);

  cop_muldiv_unit #(.DW(DW), .ITER_BITS(ITER_BITS)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (COP_OP[3:0] == OP_DIV32),
    .a      (COP_OUT[DW-1:0]),
    .b      (COP_OUT[2*DW-1:DW]),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_d  = state_q;
    res_d    = '0;
    err_d    = 1'b0;
    fin_load = 1'b0;
    case (state_q)
      S_IDLE: if (COP_GO) state_d = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_ADD64: begin res_d = a64_q + b64_q; fin_load = 1'b1; end
          OP_SUB64: begin res_d = a64_q - b64_q; fin_load = 1'b1; end
          OP_MUL32: begin res_d = md_result; fin_load = md_done; end
          OP_DIV32: begin
            if (dz_q) begin
              res_d    = {a64_q[DW-1:0], {DW{1'b1}}};
              err_d    = 1'b1;
              fin_load = 1'b1;
            end else begin
              res_d    = md_result;
              fin_load = md_done;
            end
          end
          default: begin err_d = 1'b1; fin_load = 1'b1; end
        endcase
        if (fin_load) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a64_q    <= '0;
      b64_q    <= '0;
      dz_q     <= 1'b0;
      cop_in_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= COP_OP[3:0];
        a64_q <= COP_OUT[2*DW-1:0];
        b64_q <= COP_OUT[4*DW-1:2*DW];
        dz_q  <= dz_in;
      end
      if (fin_load) begin
        cop_in_q <= res_d;
        err_q    <= err_d;
      end
    end
  end

  assign COP_DONE = (state_q == S_FIN);
  assign busy     = (state_q != S_IDLE);
  assign COP_IN   = cop_in_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cop_responder.sv
// Self-checking bench for cop_responder: directed vector table, random commands
// against an arithmetic reference model, and hand sequences for busy/reset corners.
module tb_cop_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         COP_GO;
  logic [23:0]  COP_OP;
  logic [127:0] COP_OUT;
  logic         COP_DONE;
  logic [63:0]  COP_IN;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_in;
  logic        last_err;

  always #5 clk = ~clk;

  cop_responder #(.DW(32), .ITER_BITS(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .COP_GO   (COP_GO),
    .COP_OP   (COP_OP),
    .COP_OUT  (COP_OUT),
    .COP_DONE (COP_DONE),
    .COP_IN   (COP_IN),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    logic [23:0]  op;
    logic [127:0] out;
    logic [63:0]  exp_in;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand fields.
  function automatic void model(input logic [3:0] op, input logic [127:0] out,
                                output logic [63:0] res, output logic e, output int lat);
    logic [63:0] a64, b64;
    logic [31:0] a32, b32;
    a64 = out[63:0];  b64 = out[127:64];
    a32 = out[31:0];  b32 = out[63:32];
    e = 1'b0; lat = 1; res = '0;
    case (op)
      4'd0: res = a64 + b64;
      4'd1: res = a64 - b64;
      4'd2: begin res = {32'h0, a32} * {32'h0, b32}; lat = 33; end
      4'd3: begin
        if (b32 == 0) begin res = {a32, 32'hFFFF_FFFF}; e = 1'b1; end
        else begin res = {a32 % b32, a32 / b32}; lat = 33; end
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; COP_GO = 1'b0; COP_OP = '0; COP_OUT = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {63'h0, COP_DONE}, 64'h0);
    check("rst_in", COP_IN, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_err", {63'h0, err}, 64'h0);
    rst_n = 1'b1;
    last_in = '0; last_err = 1'b0;
  endtask

  // GO driven in the cycle after the previous call's DONE cycle, so chained calls are back-to-back.
  task automatic run_cmd(input string nm, input logic [23:0] op, input logic [127:0] out,
                         input logic [63:0] exp_in, input logic exp_err, input int exp_lat);
    int n;
    @(negedge clk);
    COP_OP = op; COP_OUT = out; COP_GO = 1'b1;
    @(negedge clk);
    COP_GO = 1'b0;
    COP_OUT = {$urandom(), $urandom(), $urandom(), $urandom()};
    check({nm, " busy"}, {63'h0, busy}, 64'h1);
    check({nm, " hold_in"}, COP_IN, last_in);
    check({nm, " hold_err"}, {63'h0, err}, {63'h0, last_err});
    n = 1;
    while (!COP_DONE && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!COP_DONE) begin
      errors++; checks++;
      $display("FAIL %s timeout: no DONE after %0d cycles", nm, n);
    end else begin
      check({nm, " lat"}, 64'(n), 64'(1 + exp_lat));
      check({nm, " in"}, COP_IN, exp_in);
      check({nm, " err"}, {63'h0, err}, {63'h0, exp_err});
      check({nm, " busy_fin"}, {63'h0, busy}, 64'h1);
    end
    last_in = exp_in; last_err = exp_err;
  endtask

  vec_t vecs[11];

  initial begin
    logic [63:0]  r_in;
    logic         r_err;
    int           r_lat;
    logic [127:0] r_out;
    logic [3:0]   r_op;
    int           n, dones, done_at;
    logic [63:0]  got_in;

    vecs[0]  = '{24'h000000, {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, 64'h0, 1'b0, 1};
    vecs[1]  = '{24'h000001, {64'h1, 64'h0}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
    vecs[2]  = '{24'hABCDE0, {64'h0FED_CBA9_8765_4321, 64'h1234_5678_9ABC_DEF0},
                 64'h2222_2222_2222_2211, 1'b0, 1};
    vecs[3]  = '{24'h000002, {64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 64'hFFFF_FFFE_0000_0001, 1'b0, 33};
    vecs[4]  = '{24'h000003, {64'h0, 32'd7, 32'd100}, {32'd2, 32'd14}, 1'b0, 33};
    vecs[5]  = '{24'h000003, {64'h0, 32'd0, 32'd5}, {32'd5, 32'hFFFF_FFFF}, 1'b1, 1};
    vecs[6]  = '{24'h000009, {64'h1234, 64'h5678}, 64'h0, 1'b1, 1};
    vecs[7]  = '{24'h00000F, {64'hFFFF, 64'hFFFF}, 64'h0, 1'b1, 1};
    vecs[8]  = '{24'h000002, {64'h0, 32'h0001_0000, 32'h0001_0000}, 64'h0000_0001_0000_0000, 1'b0, 33};
    vecs[9]  = '{24'h000003, {64'h0, 32'd100, 32'd7}, {32'd7, 32'd0}, 1'b0, 33};
    vecs[10] = '{24'h000000, {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001}, 64'h1, 1'b0, 1};

    do_reset();

    for (int i = 0; i < 11; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].out,
              vecs[i].exp_in, vecs[i].exp_err, vecs[i].exp_lat);

    for (int i = 0; i < 30; i++) begin
      r_op  = ($urandom_range(0, 5) > 3) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      r_out = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 5) == 0) r_out[63:32] = 32'h0;
      model(r_op, r_out, r_in, r_err, r_lat);
      run_cmd($sformatf("rnd%0d", i), {20'($urandom()), r_op}, r_out, r_in, r_err, r_lat);
    end

    // GO pulses while busy, including the FIN cycle, must be ignored.
    r_out = {64'h0, 32'h0001_2345, 32'hDEAD_BEEF};
    model(4'd2, r_out, r_in, r_err, r_lat);
    @(negedge clk);
    COP_OP = 24'h2; COP_OUT = r_out; COP_GO = 1'b1;
    @(negedge clk);
    COP_GO = 1'b0;
    n = 1; dones = 0; done_at = 0; got_in = '0;
    while (n < 45) begin
      if (COP_DONE) begin dones++; done_at = n; got_in = COP_IN; end
      if (n == 5 || n == 20 || n == 34) begin
        COP_OP = 24'h0; COP_OUT = {64'h1, 64'h1}; COP_GO = 1'b1;
      end else begin
        COP_GO = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("busygo dones", 64'(dones), 64'h1);
    check("busygo lat", 64'(done_at), 64'(1 + r_lat));
    check("busygo in", got_in, r_in);
    check("busygo idle", {63'h0, busy}, 64'h0);
    check("busygo hold", COP_IN, r_in);
    last_in = r_in; last_err = r_err;

    // Leave err=1 and a nonzero result so the abort visibly clears them.
    run_cmd("dz", 24'h3, {64'h0, 32'd0, 32'd5}, {32'd5, 32'hFFFF_FFFF}, 1'b1, 1);

    // Reset at cycle k+10 of a MUL32 aborts it with no DONE.
    @(negedge clk);
    COP_OP = 24'h2; COP_OUT = {64'h0, 32'd3, 32'd5}; COP_GO = 1'b1;
    @(negedge clk);
    COP_GO = 1'b0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort done", {63'h0, COP_DONE}, 64'h0);
    check("abort in", COP_IN, 64'h0);
    check("abort busy", {63'h0, busy}, 64'h0);
    check("abort err", {63'h0, err}, 64'h0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (COP_DONE) dones++;
    end
    check("abort no_done", 64'(dones), 64'h0);
    last_in = '0; last_err = 1'b0;

    run_cmd("post_rst", 24'h0, {64'd40, 64'd2}, 64'd42, 1'b0, 1);
    run_cmd("post_rst2", 24'h0, {64'd1, 64'd2}, 64'd3, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
